// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//
// Sequencing controller for the multiply-accumulate datapath. A job runs
// num_terms+1 multiply/add terms. Each term loads operands, starts the
// multiplier, waits for completion (guarded by a watchdog) and then
// accumulates the product. The result is offered with a valid/ready handshake.
// An optional accumulate mode skips the accumulator clear so that a job adds
// onto the existing contents.
//
// Parameters
//   CNT_W    width of the term count/index (up to 2^CNT_W terms per job)
//   TIMEOUT  maximum WAIT cycles per term before the watchdog fires (>= 1)
//
// Ports
//   clk           clock
//   reset         synchronous, active-low reset
//   start         job request, sampled only in IDLE
//   num_terms     number of terms minus one, latched on start
//   accumulate    1 = keep accumulator contents, latched on start
//   mul_done      multiplier completion, sampled only in WAIT
//   abort         synchronous job cancel (ignored in IDLE)
//   result_ready  consumer accepts the result, sampled only in DONE
//   finish        high in IDLE
//   clr_acc_n     active-low accumulator clear
//   load_op       load operands (LOAD)
//   begin_mul     start multiplier (RUN)
//   add           accumulate product (ADD)
//   term_idx      0-based index of the current term
//   result_valid  result available (DONE)
//   error         watchdog timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             accumulate,
  input  logic             mul_done,
  input  logic             abort,
  input  logic             result_ready,
  output logic             finish,
  output logic             clr_acc_n,
  output logic             load_op,
  output logic             begin_mul,
  output logic             add,
  output logic [CNT_W-1:0] term_idx,
  output logic             result_valid,
  output logic             error
);

  // The timer only has to reach TIMEOUT-1; keep at least one bit so that
  // TIMEOUT=1 still elaborates.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_WAIT = 3'd4,
    S_ADD  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] term_idx_d;
  logic [CNT_W-1:0] terms_q, terms_d;
  logic             acc_q, acc_d;
  logic             error_d;
  logic [TMR_W-1:0] timer, timer_d;

  // ---------------------------------------------------------------------------
  // State and job-context registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state    <= S_IDLE;
      term_idx <= '0;
      error    <= 1'b0;
      terms_q  <= '0;
      acc_q    <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= state_d;
      term_idx <= term_idx_d;
      error    <= error_d;
      terms_q  <= terms_d;
      acc_q    <= acc_d;
      timer    <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and job-context update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a hold default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state;
    term_idx_d = term_idx;
    error_d    = error;
    terms_d    = terms_q;
    acc_d      = acc_q;
    timer_d    = timer;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_INIT;
          terms_d    = num_terms;
          acc_d      = accumulate;
          term_idx_d = '0;
          error_d    = 1'b0;
        end
      end
      S_INIT: state_d = S_LOAD;
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // Completion on the last allowed cycle still wins over the watchdog.
        if (mul_done) begin
          state_d = S_ADD;
        end else if (timer == TMR_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      S_ADD: begin
        // Comparing before incrementing means term_idx never wraps, even for
        // a full 2^CNT_W-term job.
        if (term_idx == terms_q) begin
          state_d = S_DONE;
        end else begin
          term_idx_d = term_idx + CNT_W'(1);
          state_d    = S_LOAD;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every in-job event and leaves the job context frozen
    // so the host can still see how far the job got.
    if (abort && (state != S_IDLE)) begin
      state_d    = S_IDLE;
      term_idx_d = term_idx;
      error_d    = error;
      timer_d    = timer;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decodes
  // ---------------------------------------------------------------------------
  assign finish       = (state == S_IDLE);
  assign load_op      = (state == S_LOAD);
  assign begin_mul    = (state == S_RUN);
  assign add          = (state == S_ADD);
  assign result_valid = (state == S_DONE);
  // The clear also follows reset combinationally so the accumulator is held
  // clear for as long as reset is asserted.
  assign clr_acc_n    = reset & ~((state == S_INIT) & ~acc_q);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             accumulate;
  logic             mul_done;
  logic             abort;
  logic             result_ready;
  logic             finish;
  logic             clr_acc_n;
  logic             load_op;
  logic             begin_mul;
  logic             add;
  logic [CNT_W-1:0] term_idx;
  logic             result_valid;
  logic             error;

  mac_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_terms    (num_terms),
    .accumulate   (accumulate),
    .mul_done     (mul_done),
    .abort        (abort),
    .result_ready (result_ready),
    .finish       (finish),
    .clr_acc_n    (clr_acc_n),
    .load_op      (load_op),
    .begin_mul    (begin_mul),
    .add          (add),
    .term_idx     (term_idx),
    .result_valid (result_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Phases of a job as the behavioural model sees them.
  typedef enum {P_IDLE, P_INIT, P_LOAD, P_RUN, P_WAIT, P_ADD, P_DONE} phase_e;

  // One clock cycle: inputs to drive and outputs expected during that cycle.
  typedef struct {
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_terms;
    logic             accumulate;
    logic             mul_done;
    logic             abort;
    logic             result_ready;
    logic             finish;
    logic             clr_acc_n;
    logic             load_op;
    logic             begin_mul;
    logic             add;
    logic             result_valid;
    logic             error;
    logic [CNT_W-1:0] term_idx;
  } vec_t;

  vec_t plan[$];
  int   k_list[$];
  int   checks = 0;
  int   errors = 0;
  int   m_idx  = 0;   // model: term_idx visible in IDLE
  int   m_err  = 0;   // model: error visible in IDLE
  int   job_lat;      // expected edges from start to result_valid, -1 none, -2 skip
  int   job_adds;     // expected number of add pulses
  int   job_no = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Packed as {finish, clr_acc_n, load_op, begin_mul, add, result_valid, error, term_idx}.
  function automatic logic [31:0] pack_exp(input vec_t v);
    return 32'({v.finish, v.clr_acc_n, v.load_op, v.begin_mul, v.add,
                v.result_valid, v.error, v.term_idx});
  endfunction

  function automatic logic [31:0] pack_dut();
    return 32'({finish, clr_acc_n, load_op, begin_mul, add,
                result_valid, error, term_idx});
  endfunction

  // Append one cycle. Inputs that the phase ignores get random noise.
  function automatic void push(input phase_e ph, input logic acc, input int idx, input logic err);
    vec_t v;
    v.rst          = 1'b1;
    v.start        = (ph == P_IDLE) ? 1'b0 : 1'($urandom_range(0, 1));
    v.num_terms    = CNT_W'($urandom);
    v.accumulate   = 1'($urandom_range(0, 1));
    v.mul_done     = (ph == P_WAIT) ? 1'b0 : 1'($urandom_range(0, 1));
    v.abort        = 1'b0;
    v.result_ready = (ph == P_DONE) ? 1'b0 : 1'($urandom_range(0, 1));
    v.finish       = (ph == P_IDLE);
    v.clr_acc_n    = !((ph == P_INIT) && !acc);
    v.load_op      = (ph == P_LOAD);
    v.begin_mul    = (ph == P_RUN);
    v.add          = (ph == P_ADD);
    v.result_valid = (ph == P_DONE);
    v.error        = err;
    v.term_idx     = CNT_W'(idx);
    plan.push_back(v);
  endfunction

  // Build the cycle-by-cycle plan for one job. k_list[t] is the number of
  // WAIT cycles before mul_done for term t; k >= TIMEOUT means it never comes.
  // cut_kind: 0 none, 1 abort, 2 reset, applied at plan index cut_at.
  task automatic build_job(input int n, input logic acc, input int rdy_delay,
                           input int cut_at, input int cut_kind);
    vec_t v;
    int   idx = 0;
    logic timed_out = 1'b0;
    plan.delete();
    push(P_IDLE, acc, m_idx, m_err[0]);
    v = plan.pop_back();
    v.start      = 1'b1;
    v.num_terms  = CNT_W'(n - 1);
    v.accumulate = acc;
    v.abort      = 1'($urandom_range(0, 1));  // abort in IDLE must be ignored
    plan.push_back(v);
    push(P_INIT, acc, 0, 1'b0);
    job_lat  = 1;
    job_adds = 0;
    for (int t = 0; t < n && !timed_out; t++) begin
      push(P_LOAD, acc, idx, 1'b0);
      push(P_RUN, acc, idx, 1'b0);
      if (k_list[t] < TIMEOUT) begin
        for (int w = 0; w <= k_list[t]; w++) push(P_WAIT, acc, idx, 1'b0);
        v = plan.pop_back();
        v.mul_done = 1'b1;
        plan.push_back(v);
        push(P_ADD, acc, idx, 1'b0);
        job_adds++;
        job_lat += k_list[t] + 4;
        if (t < n - 1) idx++;
      end else begin
        for (int w = 0; w < TIMEOUT; w++) push(P_WAIT, acc, idx, 1'b0);
        timed_out = 1'b1;
      end
    end
    if (!timed_out) begin
      for (int d = 0; d <= rdy_delay; d++) push(P_DONE, acc, idx, 1'b0);
      v = plan.pop_back();
      v.result_ready = 1'b1;
      plan.push_back(v);
    end else begin
      job_lat = -1;
    end
    m_idx = idx;
    m_err = timed_out ? 1 : 0;

    if (cut_kind == 1 && cut_at == 0) begin
      v = plan.pop_front();
      v.abort = 1'b1;
      plan.push_front(v);
    end else if (cut_kind != 0 && cut_at < plan.size()) begin
      while (plan.size() > cut_at + 1) void'(plan.pop_back());
      v = plan.pop_back();
      if (cut_kind == 1) begin
        v.abort = 1'b1;
        m_idx   = int'(v.term_idx);
        m_err   = int'(v.error);
      end else begin
        v.rst       = 1'b0;
        v.clr_acc_n = 1'b0;
        m_idx       = 0;
        m_err       = 0;
      end
      plan.push_back(v);
      job_lat  = -2;
      job_adds = 0;
      foreach (plan[i]) if (plan[i].add) job_adds++;
    end

    // One settling IDLE cycle; abort here must also be ignored.
    push(P_IDLE, acc, m_idx, m_err[0]);
    v = plan.pop_back();
    v.abort = 1'($urandom_range(0, 1));
    plan.push_back(v);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic run_plan();
    int lat  = -1;
    int adds = 0;
    job_no++;
    for (int i = 0; i < plan.size(); i++) begin
      reset        = plan[i].rst;
      start        = plan[i].start;
      num_terms    = plan[i].num_terms;
      accumulate   = plan[i].accumulate;
      mul_done     = plan[i].mul_done;
      abort        = plan[i].abort;
      result_ready = plan[i].result_ready;
      @(negedge clk);
      check($sformatf("job%0d_cyc%0d", job_no, i), pack_dut(), pack_exp(plan[i]));
      if (result_valid === 1'b1 && lat < 0) lat = i;
      if (add === 1'b1) adds++;
      @(posedge clk);
      #1;
    end
    if (job_lat != -2)
      check($sformatf("job%0d_latency", job_no), (lat < 0) ? -1 : lat - 1, job_lat);
    check($sformatf("job%0d_adds", job_no), adds, job_adds);
  endtask

  task automatic set_k(input int n, input int k);
    k_list.delete();
    for (int t = 0; t < n; t++) k_list.push_back(k);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0; start = 1'b1; num_terms = 4'd3; accumulate = 1'b0;
    mul_done = 1'b0; abort = 1'b0; result_ready = 1'b0;

    // Reset held with start high: IDLE outputs, accumulator clear asserted.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), pack_dut(), 32'b1000000_0000);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("reset_release_idle", pack_dut(), 32'b1100000_0000);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_to_init", pack_dut(), 32'b0000000_0000);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_init_to_idle", pack_dut(), 32'b1100000_0000);
    @(posedge clk); #1;
    m_idx = 0; m_err = 0;

    // Full job: 10 terms, k=0, immediate accept -> 41 edges to result_valid.
    set_k(10, 0);              build_job(10, 1'b0, 0, 0, 0);  run_plan();
    // Accumulate mode, single term -> 5 edges, no clear.
    set_k(1, 0);               build_job(1, 1'b1, 0, 0, 0);   run_plan();
    // Watchdog, then the next start clears error.
    set_k(1, TIMEOUT);         build_job(1, 1'b0, 0, 0, 0);   run_plan();
    // Completion on the final allowed WAIT cycle wins over the watchdog.
    set_k(1, TIMEOUT - 1);     build_job(1, 1'b0, 0, 0, 0);   run_plan();
    // Abort together with mul_done in WAIT (index 6 is the third WAIT cycle).
    k_list.delete(); k_list.push_back(2); k_list.push_back(0);
    build_job(2, 1'b0, 0, 6, 1);                              run_plan();
    // Backpressure: five cycles of result_ready=0 in DONE.
    set_k(2, 1);               build_job(2, 1'b0, 5, 0, 0);   run_plan();
    // Watchdog on a later term, then reset mid-job clears the error.
    k_list.delete(); k_list.push_back(0); k_list.push_back(TIMEOUT);
    build_job(2, 1'b0, 0, 0, 0);                              run_plan();
    set_k(4, 0);               build_job(4, 1'b0, 0, 14, 2);  run_plan();
    // Abort in IDLE alongside start is ignored.
    set_k(2, 0);               build_job(2, 1'b0, 1, 0, 1);   run_plan();
    // Maximum job length: 2^CNT_W terms, term_idx 0..15 without wrapping.
    set_k(16, 0);              build_job(16, 1'b0, 0, 0, 0);  run_plan();

    // Randomised jobs against the model.
    for (int j = 0; j < 30; j++) begin
      int n;
      int r;
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : $urandom_range(1, 4);
      k_list.delete();
      for (int t = 0; t < n; t++) begin
        r = $urandom_range(0, 19);
        if (r < 14)      k_list.push_back($urandom_range(0, 3));
        else if (r < 16) k_list.push_back(TIMEOUT - 1);
        else if (r < 17) k_list.push_back(TIMEOUT);
        else             k_list.push_back($urandom_range(4, 10));
      end
      r = $urandom_range(0, 5);
      build_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 30), (r == 0) ? 1 : (r == 1) ? 2 : 0);
      run_plan();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
